branch_resolve_unit: RTL and testbench

//   Consumes the registered branch/jump flags produced by the control block and

---
 rtl/branch_resolve_unit.sv | 106 ++++++++++
 tb/tb_branch_resolve_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - branch/jump resolution, PC ownership and wrong-path flush
// Resolves one control flag per valid cycle against the instruction in execute (pc_ex).
module branch_resolve_unit #(
   parameter int                PC_WIDTH     = 16,
   parameter int                DATA_WIDTH   = 16,
   parameter int                IMM_WIDTH    = 8,
   parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
   parameter int                FLUSH_CYCLES = 1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  stall,
   input  logic                  ctrl_valid,
   input  logic                  branchEq,
   input  logic                  branchNeq,
   input  logic                  branchLt,
   input  logic                  branchGt,
   input  logic                  branchLte,
   input  logic                  branchGte,
   input  logic                  jump,
   input  logic                  immType,
   input  logic [DATA_WIDTH-1:0] rs_data,
   input  logic [DATA_WIDTH-1:0] rt_data,
   input  logic [IMM_WIDTH-1:0]  imm,
   output logic [PC_WIDTH-1:0]   pc,
   output logic                  flush,
   output logic                  taken,
   output logic                  multi_flag_err,
   output logic [15:0]           taken_count
);

   localparam logic       RUN        = 1'b0;
   localparam logic       FLUSH      = 1'b1;
   localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

   logic                state;
   logic [2:0]          flushCnt;
   logic [PC_WIDTH-1:0] pc_ex;

   logic [2:0]          flagCount;
   logic                resolvable;
   logic                condMet;
   logic                redirect;
   logic                rsEqRt;
   logic                rsLtRt;
   logic                rsGtRt;
   logic [PC_WIDTH-1:0] target;

   assign flagCount = {2'b00, branchEq}  + {2'b00, branchNeq} + {2'b00, branchLt} +
                      {2'b00, branchGt}  + {2'b00, branchLte} + {2'b00, branchGte} +
                      {2'b00, jump};

   assign resolvable = ctrl_valid && (state == RUN);

   assign rsEqRt = (rs_data == rt_data);
   assign rsLtRt = ($signed(rs_data) < $signed(rt_data));
   assign rsGtRt = ($signed(rs_data) > $signed(rt_data));

   assign condMet = (branchEq  &  rsEqRt) | (branchNeq & ~rsEqRt) |
                    (branchLt  &  rsLtRt) | (branchGt  &  rsGtRt) |
                    (branchLte & ~rsGtRt) | (branchGte & ~rsLtRt) | jump;

   assign redirect = resolvable && (flagCount == 3'd1) && condMet;

   // Branch offsets are relative to the instruction in execute, not the fetch address.
   always_comb begin
      target = pc_ex + PC_WIDTH'($signed(imm));
      if (jump) begin
         if (immType) target = PC_WIDTH'(imm);
         else         target = PC_WIDTH'(rs_data);
      end
   end

   assign flush = (state == FLUSH);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc             <= RESET_PC;
         pc_ex          <= RESET_PC;
         state          <= RUN;
         flushCnt       <= '0;
         taken          <= 1'b0;
         multi_flag_err <= 1'b0;
         taken_count    <= '0;
      end else if (!stall) begin
         pc_ex <= pc;
         pc    <= redirect ? target : pc + PC_WIDTH'(1);
         taken <= redirect;
         if (redirect && taken_count != 16'hFFFF) taken_count <= taken_count + 16'd1;
         if (resolvable && flagCount > 3'd1) multi_flag_err <= 1'b1;
         case (state)
            RUN: begin
               if (redirect) begin
                  state    <= FLUSH;
                  flushCnt <= FLUSH_INIT;
               end
            end
            default: begin
               if (flushCnt == 3'd0) state    <= RUN;
               else                  flushCnt <= flushCnt - 3'd1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed plus randomized bench for branch_resolve_unit
// Reference model tracks pc, execute pc and remaining flush cycles as plain integers.
module tb_branch_resolve_unit;

   localparam int           FLUSH_N  = 2;
   localparam logic [15:0]  RST_PC   = 16'h0040;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        stall;
   logic        ctrl_valid;
   logic [6:0]  flags;
   logic        immType;
   logic [15:0] rs_data;
   logic [15:0] rt_data;
   logic [7:0]  imm;
   logic [15:0] pc;
   logic        flush;
   logic        taken;
   logic        multi_flag_err;
   logic [15:0] taken_count;

   int tests = 0;
   int fails = 0;

   logic [15:0] m_pc;
   logic [15:0] m_pcex;
   int          m_flushLeft;
   logic        m_taken;
   logic        m_err;
   int          m_count;

   branch_resolve_unit #(
      .PC_WIDTH(16), .DATA_WIDTH(16), .IMM_WIDTH(8),
      .RESET_PC(RST_PC), .FLUSH_CYCLES(FLUSH_N)
   ) dut (
      .clock(clock), .reset_n(reset_n), .stall(stall), .ctrl_valid(ctrl_valid),
      .branchEq(flags[0]), .branchNeq(flags[1]), .branchLt(flags[2]), .branchGt(flags[3]),
      .branchLte(flags[4]), .branchGte(flags[5]), .jump(flags[6]), .immType(immType),
      .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
      .pc(pc), .flush(flush), .taken(taken), .multi_flag_err(multi_flag_err),
      .taken_count(taken_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic compareAll();
      chk("pc", {16'h0, pc}, {16'h0, m_pc});
      chk("flush", {31'h0, flush}, {31'h0, (m_flushLeft > 0)});
      chk("taken", {31'h0, taken}, {31'h0, m_taken});
      chk("multi_flag_err", {31'h0, multi_flag_err}, {31'h0, m_err});
      chk("taken_count", {16'h0, taken_count}, m_count);
   endtask

   task automatic modelReset();
      m_pc = RST_PC; m_pcex = RST_PC; m_flushLeft = 0;
      m_taken = 1'b0; m_err = 1'b0; m_count = 0;
   endtask

   task automatic modelStep();
      int a, b, t;
      logic go;
      if (stall) return;
      go = 1'b0;
      t  = 0;
      if (m_flushLeft > 0) begin
         m_flushLeft--;
      end else if (ctrl_valid) begin
         if ($countones(flags) > 1) begin
            m_err = 1'b1;
         end else if ($countones(flags) == 1) begin
            a = $signed(rs_data);
            b = $signed(rt_data);
            if (flags[6]) begin
               go = 1'b1;
               t  = immType ? int'(imm) : int'(rs_data);
            end else begin
               if (flags[0]) go = (a == b);
               if (flags[1]) go = (a != b);
               if (flags[2]) go = (a <  b);
               if (flags[3]) go = (a >  b);
               if (flags[4]) go = (a <= b);
               if (flags[5]) go = (a >= b);
               t = int'(m_pcex) + int'($signed(imm));
            end
         end
      end
      m_taken = go;
      m_pcex  = m_pc;
      if (go) begin
         m_pc        = 16'(t);
         m_flushLeft = FLUSH_N;
         if (m_count < 65535) m_count++;
      end else begin
         m_pc = m_pc + 16'd1;
      end
   endtask

   task automatic cycle(input logic st, input logic cv, input logic [6:0] f, input logic it,
                        input logic [15:0] rs, input logic [15:0] rt, input logic [7:0] im);
      stall = st; ctrl_valid = cv; flags = f; immType = it;
      rs_data = rs; rt_data = rt; imm = im;
      modelStep();
      @(posedge clock);
      #1;
      compareAll();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 7'h00, 1'b0, 16'h0, 16'h0, 8'h0);
   endtask

   task automatic doReset();
      reset_n = 1'b0;
      #1;
      modelReset();
      compareAll();
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   initial begin
      stall = 0; ctrl_valid = 0; flags = 0; immType = 0;
      rs_data = 0; rt_data = 0; imm = 0; reset_n = 1'b1;
      #3;
      doReset();

      // reset value and free-running increment
      chk("t1_reset_pc", {16'h0, pc}, 32'h0040);
      for (int i = 1; i <= 3; i++) begin
         idle(1);
         chk("t1_pc_inc", {16'h0, pc}, 32'h0040 + i);
         chk("t1_flush", {31'h0, flush}, 32'h0);
      end

      // jump to 0x0E, then three cycles puts pc_ex at 0x0010
      cycle(0, 1, 7'h40, 1, 16'h0, 16'h0, 8'h0E);
      chk("t2_jump_pc", {16'h0, pc}, 32'h000E);
      idle(3);
      cycle(0, 1, 7'h01, 0, 16'd5, 16'd5, 8'hFC);
      chk("t2_beq_pc", {16'h0, pc}, 32'h000C);
      chk("t2_beq_taken", {31'h0, taken}, 32'h1);
      chk("t2_beq_flush", {31'h0, flush}, 32'h1);
      chk("t2_count", {16'h0, taken_count}, 32'd2);
      idle(1);
      chk("t2_taken_pulse", {31'h0, taken}, 32'h0);
      chk("t2_flush_2nd", {31'h0, flush}, 32'h1);
      idle(1);
      chk("t2_flush_done", {31'h0, flush}, 32'h0);
      chk("t2_pc_after", {16'h0, pc}, 32'h000E);

      // signed compare: -1 > 1 false, -1 < 1 true
      cycle(0, 1, 7'h08, 0, 16'hFFFF, 16'h0001, 8'h02);
      chk("t3_bgt_pc", {16'h0, pc}, 32'h000F);
      chk("t3_bgt_taken", {31'h0, taken}, 32'h0);
      cycle(0, 1, 7'h04, 0, 16'hFFFF, 16'h0001, 8'h02);
      chk("t3_blt_pc", {16'h0, pc}, 32'h0010);
      chk("t3_blt_taken", {31'h0, taken}, 32'h1);
      idle(2);

      cycle(0, 1, 7'h40, 1, 16'h0, 16'h0, 8'h80);
      chk("t4_jimm_pc", {16'h0, pc}, 32'h0080);
      idle(2);
      cycle(0, 1, 7'h40, 0, 16'h1234, 16'h0, 8'h80);
      chk("t4_jreg_pc", {16'h0, pc}, 32'h1234);
      idle(2);

      // stall during flush, flags offered while flushing
      cycle(0, 1, 7'h40, 1, 16'h0, 16'h0, 8'h20);
      chk("t5_pc", {16'h0, pc}, 32'h0020);
      for (int i = 0; i < 3; i++) begin
         cycle(1, 1, 7'h40, 1, 16'h0, 16'h0, 8'h55);
         chk("t5_stall_pc", {16'h0, pc}, 32'h0020);
         chk("t5_stall_flush", {31'h0, flush}, 32'h1);
         chk("t5_stall_taken", {31'h0, taken}, 32'h1);
      end
      cycle(0, 1, 7'h40, 1, 16'h0, 16'h0, 8'h55);
      chk("t5_ign1_pc", {16'h0, pc}, 32'h0021);
      chk("t5_ign1_flush", {31'h0, flush}, 32'h1);
      cycle(0, 1, 7'h40, 1, 16'h0, 16'h0, 8'h55);
      chk("t5_ign2_pc", {16'h0, pc}, 32'h0022);
      chk("t5_run_flush", {31'h0, flush}, 32'h0);
      cycle(0, 1, 7'h40, 1, 16'h0, 16'h0, 8'h55);
      chk("t5_run_jump", {16'h0, pc}, 32'h0055);
      idle(2);

      cycle(0, 1, 7'h41, 1, 16'd7, 16'd7, 8'h10);
      chk("t6_multi_pc", {16'h0, pc}, 32'h0058);
      chk("t6_multi_err", {31'h0, multi_flag_err}, 32'h1);
      chk("t6_multi_taken", {31'h0, taken}, 32'h0);
      idle(1);
      chk("t6_err_sticky", {31'h0, multi_flag_err}, 32'h1);
      doReset();
      chk("t6_err_cleared", {31'h0, multi_flag_err}, 32'h0);
      chk("t6_reset_pc", {16'h0, pc}, 32'h0040);

      for (int n = 0; n < 3000; n++) begin
         logic [6:0]  f;
         logic [15:0] a, b;
         int          r;
         if ($urandom_range(249) == 0) begin
            @(negedge clock);
            doReset();
         end
         r = int'($urandom_range(39));
         if (r == 0) begin
            f = 7'(1 << $urandom_range(6));
            f = f | 7'(1 << $urandom_range(6));
            if ($countones(f) < 2) f = f | 7'h01 | 7'h40;
         end else if (r < 10) begin
            f = 7'h00;
         end else begin
            f = 7'(1 << $urandom_range(6));
         end
         a = ($urandom_range(2) == 0) ? 16'($urandom_range(3)) : 16'($urandom);
         b = ($urandom_range(2) == 0) ? a : 16'($urandom_range(3) - 1);
         cycle(($urandom_range(5) == 0), ($urandom_range(4) != 0), f, 1'($urandom),
               a, b, 8'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
